msg_stream_seq: RTL

- Parametrised ASCII message streamer, the successor to the fixed two-message character sequencer.
- Holds NUM_MSG messages of up to MAX_LEN characters in an internal ROM.
- On a start request, emits the selected message one character per valid/ready beat, in one-shot or loop mode.
- Sits between the chip's user inputs and the 8-bit output pins, or any downstream character sink.

---
 rtl/msg_stream_pkg.sv | 37 +++
 rtl/msg_rom.sv | 32 +++
 rtl/msg_stream_seq.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/msg_stream_pkg.sv
// ---------------------------------------------------------------------------
// msg_stream_pkg
// Shared constants for the ASCII message streamer: FSM state encodings,
// default geometry, message lengths and the message text ROM contents.
// Message text is stored right-justified in a packed vector, first
// character in the most significant occupied byte.
// ---------------------------------------------------------------------------
package msg_stream_pkg;

    localparam int ROM_CHAR_W  = 8;
    localparam int ROM_NUM_MSG = 4;
    localparam int ROM_MAX_LEN = 16;

    // FSM state encodings
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    typedef logic [ROM_MAX_LEN*ROM_CHAR_W-1:0] msg_text_t;

    localparam int MSG_LEN [ROM_NUM_MSG] = '{9, 7, 6, 13};

    localparam msg_text_t MSG_TEXT [ROM_NUM_MSG] = '{
        {56'h0, "Guatemala"},
        {72'h0, "Quetzal"},
        {80'h0, "Zacapa"},
        {24'h0, "Soy de Zacapa"}
    };

    // Length of message m; selectors outside the populated range read as 0.
    function automatic int msg_len(input int m, input int num_msg);
        if (m < 0 || m >= num_msg || m >= ROM_NUM_MSG)
            return 0;
        return MSG_LEN[m];
    endfunction

endpackage

// File: rtl/msg_rom.sv
// ---------------------------------------------------------------------------
// msg_rom
// Combinational message ROM lookup.
//   msg : message selector
//   idx : character index within the message
//   ch  : character at (msg, idx); 0 when msg or idx is out of range
// ---------------------------------------------------------------------------
module msg_rom
    import msg_stream_pkg::*;
#(
    parameter int CHAR_W  = ROM_CHAR_W,
    parameter int NUM_MSG = ROM_NUM_MSG,
    parameter int MAX_LEN = ROM_MAX_LEN,
    parameter int SEL_W   = $clog2(NUM_MSG),
    parameter int IDX_W   = $clog2(MAX_LEN)
) (
    input  logic [SEL_W-1:0]  msg,
    input  logic [IDX_W-1:0]  idx,
    output logic [CHAR_W-1:0] ch
);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        ch = '0;
        for (int m = 0; m < ROM_NUM_MSG; m++) begin
            if (m < NUM_MSG && int'(msg) == m && int'(idx) < MSG_LEN[m]) begin
                ch = CHAR_W'(MSG_TEXT[m][(MSG_LEN[m] - 1 - int'(idx)) * ROM_CHAR_W +: ROM_CHAR_W]);
            end
        end
    end

endmodule

// File: rtl/msg_stream_seq.sv
// ---------------------------------------------------------------------------
// msg_stream_seq
// Streams a stored ASCII message one character per valid/ready beat,
// one-shot or looping.
//   clk, reset      : clock, asynchronous active-low reset
//   en              : enables character loading and start acceptance
//   start, stop     : begin a message (IDLE only) / abort the current one
//   select, loop    : message number and repeat mode, latched on start
//   q_out, q_valid  : registered character and its valid flag
//   q_ready         : sink ready; a beat transfers on q_valid & q_ready
//   busy            : high while streaming
//   done            : one-cycle pulse after the last beat of a one-shot
//   wrap            : one-cycle pulse with the index-0 reload in loop mode
//   idx             : index of the character on q_out
// ---------------------------------------------------------------------------
module msg_stream_seq
    import msg_stream_pkg::*;
#(
    parameter int CHAR_W  = ROM_CHAR_W,
    parameter int NUM_MSG = ROM_NUM_MSG,
    parameter int MAX_LEN = ROM_MAX_LEN,
    parameter int SEL_W   = $clog2(NUM_MSG),
    parameter int IDX_W   = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              start,
    input  logic              stop,
    input  logic [SEL_W-1:0]  select,
    input  logic              loop,
    output logic [CHAR_W-1:0] q_out,
    output logic              q_valid,
    input  logic              q_ready,
    output logic              busy,
    output logic              done,
    output logic              wrap,
    output logic [IDX_W-1:0]  idx
);

    logic [1:0]        state;
    logic [SEL_W-1:0]  sel_q;
    logic              loop_q;
    logic [IDX_W-1:0]  load_idx;   // next index to load after an en stall
    logic              wrap_pend;  // stalled load is the loop restart

    logic [SEL_W-1:0]  rom_sel;
    logic [IDX_W-1:0]  rom_idx;
    logic [CHAR_W-1:0] rom_ch;
    logic              beat;
    logic              last;
    int                cur_len;
    int                sel_len;

    assign beat    = q_valid & q_ready;
    assign cur_len = msg_len(int'(sel_q), NUM_MSG);
    assign sel_len = msg_len(int'(select), NUM_MSG);
    assign last    = (int'(idx) == cur_len - 1);
    assign busy    = (state == STREAM);

    // In IDLE the selector is not yet latched, so look up the live input.
    assign rom_sel = (state == IDLE) ? select : sel_q;

    always_comb begin
        rom_idx = '0;
        if (state == STREAM) begin
            if (q_valid)
                rom_idx = last ? '0 : idx + IDX_W'(1);
            else
                rom_idx = load_idx;
        end
    end

    msg_rom #(
        .CHAR_W  (CHAR_W),
        .NUM_MSG (NUM_MSG),
        .MAX_LEN (MAX_LEN),
        .SEL_W   (SEL_W),
        .IDX_W   (IDX_W)
    ) u_rom (
        .msg (rom_sel),
        .idx (rom_idx),
        .ch  (rom_ch)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sel_q     <= '0;
            loop_q    <= 1'b0;
            load_idx  <= '0;
            wrap_pend <= 1'b0;
            q_out     <= '0;
            q_valid   <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            idx       <= '0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    // stop outranks start; an empty message skips straight to DONE
                    if (start && !stop && en) begin
                        if (sel_len != 0) begin
                            state     <= STREAM;
                            sel_q     <= select;
                            loop_q    <= loop;
                            q_out     <= rom_ch;
                            q_valid   <= 1'b1;
                            idx       <= '0;
                            wrap_pend <= 1'b0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (stop) begin
                        state     <= IDLE;
                        q_valid   <= 1'b0;
                        wrap_pend <= 1'b0;
                    end else if (beat) begin
                        if (last && !loop_q) begin
                            state   <= DONE;
                            q_valid <= 1'b0;
                            done    <= 1'b1;
                        end else if (en) begin
                            q_out   <= rom_ch;
                            q_valid <= 1'b1;
                            idx     <= rom_idx;
                            wrap    <= last;
                        end else begin
                            q_valid   <= 1'b0;
                            load_idx  <= rom_idx;
                            wrap_pend <= last;
                        end
                    end else if (!q_valid && en) begin
                        q_out     <= rom_ch;
                        q_valid   <= 1'b1;
                        idx       <= load_idx;
                        wrap      <= wrap_pend;
                        wrap_pend <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
